// File: rtl/button_encoder_pkg.sv
// Shared FSM state encodings, colour codes and one-hot helpers for button_encoder.
package button_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    PRESS_S = 2'd1,
    HELD_S  = 2'd2,
    REL_S   = 2'd3
  } state_t;

  localparam logic [1:0] COLOUR_0 = 2'd0;
  localparam logic [1:0] COLOUR_1 = 2'd1;
  localparam logic [1:0] COLOUR_2 = 2'd2;
  localparam logic [1:0] COLOUR_3 = 2'd3;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Only called on a vector already known to be one-hot.
  function automatic logic [1:0] colour_of(input logic [3:0] v);
    logic [1:0] c;
    c = COLOUR_0;
    case (v)
      4'b0010: c = COLOUR_1;
      4'b0100: c = COLOUR_2;
      4'b1000: c = COLOUR_3;
      default: c = COLOUR_0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/button_encoder_btn_sync.sv
// Parameterised-width two-flop synchroniser, asynchronously reset to zero.
module btn_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_encoder.sv
// Synchronise, debounce and encode four player buttons into IN/IN_VALID.
// Optional inactivity TIMEOUT pulse is built only when INPUT_TIMEOUT_EN is defined.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned TIMEOUT_TICKS  = 3000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       TICK,
  input  logic       ENABLE,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       TIMEOUT
);

  localparam logic [7:0] DBC_LAST = 8'(DEBOUNCE_TICKS - 1);

  logic [3:0] s;
  state_t     state_q, state_d;
  logic [7:0] dbc_q, dbc_d;
  logic [3:0] cap_q, cap_d;
  logic [1:0] in_q, in_d;
  logic       valid_q, valid_d;

  btn_sync #(.WIDTH(4)) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (BTN),
    .q     (s)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= REL_S;
      dbc_q   <= '0;
      cap_q   <= '0;
      in_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dbc_q   <= dbc_d;
      cap_q   <= cap_d;
      in_q    <= in_d;
      valid_q <= valid_d;
    end
  end

  // Every state transition reloads dbc, so a coincident TICK never counts twice.
  always_comb begin
    state_d = state_q;
    dbc_d   = dbc_q;
    cap_d   = cap_q;
    in_d    = in_q;
    valid_d = 1'b0;
    if (!ENABLE) begin
      state_d = REL_S;
      dbc_d   = '0;
    end else begin
      case (state_q)
        IDLE_S: begin
          if (is_onehot(s)) begin
            state_d = PRESS_S;
            cap_d   = s;
            dbc_d   = '0;
          end else if (s != '0) begin
            state_d = REL_S;
            dbc_d   = '0;
          end
        end
        PRESS_S: begin
          if (s != cap_q) begin
            state_d = IDLE_S;
            dbc_d   = '0;
          end else if (TICK) begin
            if (dbc_q == DBC_LAST) begin
              state_d = HELD_S;
              dbc_d   = '0;
              in_d    = colour_of(cap_q);
              valid_d = 1'b1;
            end else begin
              dbc_d = dbc_q + 8'd1;
            end
          end
        end
        HELD_S: begin
          if (s == '0) begin
            state_d = REL_S;
            dbc_d   = '0;
          end
        end
        REL_S: begin
          if (s != '0) begin
            dbc_d = '0;
          end else if (TICK) begin
            if (dbc_q == DBC_LAST) begin
              state_d = IDLE_S;
              dbc_d   = '0;
            end else begin
              dbc_d = dbc_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = REL_S;
          dbc_d   = '0;
        end
      endcase
    end
  end

  assign IN       = in_q;
  assign IN_VALID = valid_q;

`ifdef INPUT_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_TICKS - 1);

  logic [15:0] idle_cnt_q;
  logic        timeout_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (!ENABLE || state_q != IDLE_S) begin
        idle_cnt_q <= '0;
      end else if (TICK) begin
        if (idle_cnt_q == IDLE_LAST) begin
          idle_cnt_q <= '0;
          timeout_q  <= 1'b1;
        end else begin
          idle_cnt_q <= idle_cnt_q + 16'd1;
        end
      end
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_button_encoder.sv
// Self-checking bench for button_encoder: scoreboard of expected colour codes per press.
module tb_button_encoder;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BTN;
  logic       TICK;
  logic       ENABLE;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       TIMEOUT;

  int errors = 0;
  int checks = 0;
  int tick_div = 1;
  int timeout_pulses = 0;
  logic prev_valid = 1'b0;
  logic [1:0] exp_q[$];

  always #5 CLK = ~CLK;

  button_encoder #(.DEBOUNCE_TICKS(4), .TIMEOUT_TICKS(10)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .BTN      (BTN),
    .TICK     (TICK),
    .ENABLE   (ENABLE),
    .IN       (IN),
    .IN_VALID (IN_VALID),
    .TIMEOUT  (TIMEOUT)
  );

  initial begin
    int tcnt;
    tcnt = 0;
    TICK = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      tcnt++;
      TICK = (tick_div <= 1) || (tcnt % tick_div == 0);
    end
  end

  // Output side of the scoreboard: every IN_VALID pulse must match a queued press.
  always @(negedge CLK) begin
    logic [1:0] e;
    if (RST_N && IN_VALID) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL back_to_back_valid: got IN_VALID=1 on two cycles, expected single-cycle pulse");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse at %0t: got IN_VALID=1 IN=%0d, expected no pulse", $time, IN);
      end else begin
        e = exp_q.pop_front();
        if (IN !== e) begin
          errors++;
          $display("FAIL pulse_colour at %0t: got IN=%0d expected %0d", $time, IN, e);
        end
      end
    end
    if (RST_N && TIMEOUT === 1'b1) timeout_pulses++;
    prev_valid = IN_VALID;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulse: got %0d pulses outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_in(input string name, input logic [1:0] want);
    checks++;
    if (IN !== want) begin
      errors++;
      $display("FAIL %s_in_hold: got IN=%0d expected %0d", name, IN, want);
    end
  endtask

  task automatic measure_latency(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (IN_VALID === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_N  = 1'b0;
    BTN    = '0;
    ENABLE = 1'b1;
    step(3);
    checks += 3;
    if (IN !== 2'd0) begin errors++; $display("FAIL reset_in: got %0d expected 0", IN); end
    if (IN_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", IN_VALID); end
    if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", TIMEOUT); end
    RST_N = 1'b1;
    step(10);
  endtask

  task automatic test_clean_press();
    int lat;
    exp_q.push_back(2'd2);
    BTN = 4'b0100;
    measure_latency(lat);
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL clean_latency: got %0d cycles expected 7", lat);
    end
    step(13);
    BTN = '0;
    step(12);
    wait_drain("clean", 5);
    check_in("clean", 2'd2);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      BTN = 4'b0010;
      step(2);
      BTN = '0;
      step(2);
    end
    exp_q.push_back(2'd1);
    BTN = 4'b0010;
    step(20);
    BTN = '0;
    step(12);
    wait_drain("bounce", 5);
    check_in("bounce", 2'd1);
  endtask

  task automatic test_chord();
    BTN = 4'b0011;
    step(20);
    BTN = '0;
    step(12);
    check_in("chord_none", 2'd1);
    exp_q.push_back(2'd3);
    BTN = 4'b1000;
    step(12);
    BTN = 4'b1001;
    step(10);
    BTN = '0;
    step(12);
    wait_drain("chord", 5);
    check_in("chord", 2'd3);
  endtask

  task automatic test_enable();
    ENABLE = 1'b0;
    BTN = 4'b0001;
    step(10);
    ENABLE = 1'b1;
    step(20);
    BTN = '0;
    step(12);
    check_in("enable_none", 2'd3);
    exp_q.push_back(2'd0);
    BTN = 4'b0001;
    step(15);
    BTN = '0;
    step(12);
    wait_drain("enable", 5);
    check_in("enable", 2'd0);
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(2'd1);
    BTN = 4'b0010;
    step(15);
    BTN = '0;
    step(12);
    wait_drain("pre_reset", 5);
    BTN = 4'b0100;
    step(4);
    RST_N = 1'b0;
    #1;
    checks += 2;
    if (IN !== 2'd0) begin errors++; $display("FAIL midreset_in: got %0d expected 0", IN); end
    if (IN_VALID !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b expected 0", IN_VALID); end
    step(2);
    RST_N = 1'b1;
    step(20);
    BTN = '0;
    step(12);
    check_in("held_through_reset", 2'd0);
    exp_q.push_back(2'd2);
    BTN = 4'b0100;
    step(15);
    BTN = '0;
    step(12);
    wait_drain("post_reset", 5);
  endtask

  task automatic test_slow_tick();
    int lat;
    tick_div = 4;
    step(8);
    exp_q.push_back(2'd3);
    BTN = 4'b1000;
    measure_latency(lat);
    checks++;
    if (lat < 16 || lat > 19) begin
      errors++;
      $display("FAIL slow_tick_latency: got %0d cycles expected 16..19", lat);
    end
    step(5);
    BTN = '0;
    step(30);
    wait_drain("slow_tick", 5);
    tick_div = 1;
    step(4);
  endtask

  task automatic test_timeout();
`ifdef INPUT_TIMEOUT_EN
    int gap;
    int before;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (TIMEOUT === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_first: got no TIMEOUT in 30 cycles, expected a pulse");
    end
    gap = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (TIMEOUT === 1'b1) begin
        gap = i;
        break;
      end
    end
    checks++;
    if (gap != 10) begin
      errors++;
      $display("FAIL timeout_period: got %0d cycles expected 10", gap);
    end
    step(4);
    before = timeout_pulses;
    exp_q.push_back(2'd0);
    BTN = 4'b0001;
    step(25);
    checks++;
    if (timeout_pulses != before) begin
      errors++;
      $display("FAIL timeout_suppressed: got %0d pulses expected 0", timeout_pulses - before);
    end
    BTN = '0;
    step(12);
    wait_drain("timeout_press", 5);
`else
    step(40);
    checks++;
    if (timeout_pulses != 0) begin
      errors++;
      $display("FAIL timeout_disabled: got %0d pulses expected 0", timeout_pulses);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_enable();
    test_reset_mid();
    test_slow_tick();
    test_timeout();
    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
